// File: rtl/memory_port_arbiter.sv
// Shares one byte-wide memory port between scalar and 16-lane vector accesses.
// Vector accesses are serialized one lane per cycle. The pipeline stall is held until the access completes.
module memory_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LANES  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scalar_req,
    input  logic                      scalar_we,
    input  logic [ADDR_W-1:0]         scalar_addr,
    input  logic [DATA_W-1:0]         scalar_wdata,
    output logic [DATA_W-1:0]         scalar_rdata,
    output logic                      scalar_done,
    input  logic                      vector_req,
    input  logic                      vector_we,
    input  logic [ADDR_W-1:0]         vector_addr,
    input  logic [LANES*DATA_W-1:0]   vector_wdata,
    output logic [LANES*DATA_W-1:0]   vector_rdata,
    output logic                      vector_done,
    output logic                      stall,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int VEC_W  = LANES * DATA_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        S_ACC,
        S_RESP,
        V_ACC,
        V_DRAIN,
        DONE
    } state_t;

    state_t              state_q;
    logic                serve_vec_q;
    logic                we_q;
    logic [LANE_W-1:0]   lane_q;
    logic [VEC_W-1:0]    vec_wdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_we_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   scalar_rdata_q;
    logic [VEC_W-1:0]    vector_rdata_q;
    logic                scalar_done_q;
    logic                vector_done_q;

    logic [LANE_W-1:0]   lane_d;
    logic [LANE_W-1:0]   prev_lane;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wlane [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_wlane
        assign wlane[gi] = vec_wdata_q[gi*DATA_W +: DATA_W];
    end

    // Address increment wraps naturally at the top of the address space.
    assign lane_d    = lane_q + 1'b1;
    assign prev_lane = lane_q - 1'b1;
    assign addr_d    = mem_addr_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            serve_vec_q    <= 1'b0;
            we_q           <= 1'b0;
            lane_q         <= '0;
            vec_wdata_q    <= '0;
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
            scalar_rdata_q <= '0;
            vector_rdata_q <= '0;
            scalar_done_q  <= 1'b0;
            vector_done_q  <= 1'b0;
        end else begin
            scalar_done_q <= 1'b0;
            vector_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (scalar_req) begin
                        serve_vec_q <= 1'b0;
                        we_q        <= scalar_we;
                        mem_addr_q  <= scalar_addr;
                        mem_we_q    <= scalar_we;
                        mem_wdata_q <= scalar_wdata;
                        state_q     <= S_ACC;
                    end else if (vector_req) begin
                        serve_vec_q <= 1'b1;
                        we_q        <= vector_we;
                        vec_wdata_q <= vector_wdata;
                        lane_q      <= '0;
                        mem_addr_q  <= vector_addr;
                        mem_we_q    <= vector_we;
                        mem_wdata_q <= vector_wdata[DATA_W-1:0];
                        state_q     <= V_ACC;
                    end
                end
                S_ACC: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_RESP;
                end
                S_RESP: begin
                    if (!we_q) begin
                        scalar_rdata_q <= mem_rdata;
                    end
                    scalar_done_q <= 1'b1;
                    state_q       <= DONE;
                end
                V_ACC: begin
                    // Read data lags the address by one cycle, so this cycle returns the previous lane.
                    if (!we_q && lane_q != '0) begin
                        vector_rdata_q[prev_lane*DATA_W +: DATA_W] <= mem_rdata;
                    end
                    if (lane_q == LAST_LANE) begin
                        mem_we_q <= 1'b0;
                        if (we_q) begin
                            vector_done_q <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            state_q <= V_DRAIN;
                        end
                    end else begin
                        lane_q      <= lane_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wlane[lane_d];
                    end
                end
                V_DRAIN: begin
                    vector_rdata_q[LAST_LANE*DATA_W +: DATA_W] <= mem_rdata;
                    vector_done_q <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // In DONE the pipeline only keeps stalling if the other requester is waiting.
    always_comb begin
        stall = 1'b1;
        case (state_q)
            IDLE:    stall = scalar_req | vector_req;
            DONE:    stall = serve_vec_q ? scalar_req : vector_req;
            default: stall = 1'b1;
        endcase
    end

    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign scalar_rdata = scalar_rdata_q;
    assign vector_rdata = vector_rdata_q;
    assign scalar_done  = scalar_done_q;
    assign vector_done  = vector_done_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed scalar/vector accesses against a byte memory model.
module tb_memory_port_arbiter;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          scalar_req = 1'b0;
    logic          scalar_we = 1'b0;
    logic [15:0]   scalar_addr = '0;
    logic [7:0]    scalar_wdata = '0;
    logic [7:0]    scalar_rdata;
    logic          scalar_done;
    logic          vector_req = 1'b0;
    logic          vector_we = 1'b0;
    logic [15:0]   vector_addr = '0;
    logic [127:0]  vector_wdata = '0;
    logic [127:0]  vector_rdata;
    logic          vector_done;
    logic          stall;
    logic [15:0]   mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = '0;

    memory_port_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .scalar_req   (scalar_req),
        .scalar_we    (scalar_we),
        .scalar_addr  (scalar_addr),
        .scalar_wdata (scalar_wdata),
        .scalar_rdata (scalar_rdata),
        .scalar_done  (scalar_done),
        .vector_req   (vector_req),
        .vector_we    (vector_we),
        .vector_addr  (vector_addr),
        .vector_wdata (vector_wdata),
        .vector_rdata (vector_rdata),
        .vector_done  (vector_done),
        .stall        (stall),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory with one-cycle read latency.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cy;
    } wr_t;
    wr_t wr_log[$];

    always @(negedge clk) begin
        wr_t w;
        if (reset && mem_we) begin
            w.addr = mem_addr;
            w.data = mem_wdata;
            w.cy   = cyc;
            wr_log.push_back(w);
        end
    end

    typedef struct {
        bit           is_vec;
        bit           is_load;
        logic [127:0] exp;
        int           lat;
        int           issue;
    } sb_t;
    sb_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever a done pulse appears.
    always @(negedge clk) begin
        sb_t e;
        if (reset && (scalar_done || vector_done)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got scalar_done=%0b vector_done=%0b expected none",
                         scalar_done, vector_done);
            end else begin
                e = sb_q.pop_front();
                check("done_kind", {127'd0, vector_done}, {127'd0, e.is_vec});
                check("done_latency", 128'(cyc - e.issue), 128'(e.lat));
                if (e.is_load) begin
                    if (e.is_vec) check("vector_rdata", vector_rdata, e.exp);
                    else          check("scalar_rdata", {120'd0, scalar_rdata}, e.exp);
                end
                $display("txn %s %s lat=%0d rdata=%0h", e.is_vec ? "vector" : "scalar",
                         e.is_load ? "load" : "store", cyc - e.issue,
                         e.is_vec ? vector_rdata : {120'd0, scalar_rdata});
            end
        end
    end

    bit stall_tr [0:63];

    task automatic wait_done(input bit vec, input int budget);
        int  c = 0;
        bit  seen = 0;
        while (!seen && c < budget) begin
            @(posedge clk);
            #1;
            c++;
            stall_tr[c] = stall;
            seen = vec ? vector_done : scalar_done;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no %s done within %0d cycles expected a pulse",
                     vec ? "vector" : "scalar", budget);
        end
    endtask

    task automatic push_exp(input bit vec, input bit load, input logic [127:0] exp, input int lat);
        sb_t e;
        e.is_vec  = vec;
        e.is_load = load;
        e.exp     = exp;
        e.lat     = lat;
        e.issue   = cyc;
        sb_q.push_back(e);
    endtask

    task automatic do_scalar(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                             input logic [7:0] exp);
        @(posedge clk);
        #1;
        scalar_we    = we;
        scalar_addr  = addr;
        scalar_wdata = wd;
        scalar_req   = 1'b1;
        push_exp(1'b0, !we, {120'd0, exp}, 3);
        wait_done(1'b0, 20);
        scalar_req = 1'b0;
    endtask

    task automatic do_vector(input bit we, input logic [15:0] addr, input logic [127:0] wd,
                             input logic [127:0] exp, input int lat);
        @(posedge clk);
        #1;
        vector_we    = we;
        vector_addr  = addr;
        vector_wdata = wd;
        vector_req   = 1'b1;
        push_exp(1'b1, !we, exp, lat);
        wait_done(1'b1, 40);
        vector_req = 1'b0;
    endtask

    localparam logic [127:0] PAT_RAMP = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] PAT_RST  = 128'h5F5E5D5C5B5A59585756555453525150;
    localparam logic [127:0] PAT_WRAP = 128'h3736353433323130E7E6E5E4E3E2E1E0;

    initial begin
        bit ok;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            mem[16'hFFF8 + k] = 8'hE0 + 8'(k);
            mem[k]            = 8'h30 + 8'(k);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_we",   {127'd0, mem_we}, 128'd0);
        check("rst_mem_addr", {112'd0, mem_addr}, 128'd0);
        check("rst_mem_wdata",{120'd0, mem_wdata}, 128'd0);
        check("rst_dones",    {126'd0, scalar_done, vector_done}, 128'd0);
        check("rst_rdata",    vector_rdata | {120'd0, scalar_rdata}, 128'd0);
        check("rst_stall",    {127'd0, stall}, 128'd0);
        #5;
        reset = 1'b1;

        // 1: reset in the middle of a vector store
        @(posedge clk);
        #1;
        wr_log.delete();
        vector_we    = 1'b1;
        vector_addr  = 16'h0100;
        vector_wdata = PAT_RST;
        vector_req   = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t1_lane5_addr", {112'd0, mem_addr}, 128'h0105);
        check("t1_lane5_we",   {127'd0, mem_we}, 128'd1);
        check("t1_lane5_data", {120'd0, mem_wdata}, 128'h55);
        reset = 1'b0;
        #1;
        check("t1_async_we", {127'd0, mem_we}, 128'd0);
        vector_req = 1'b0;
        #20;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t1_post_stall", {127'd0, stall}, 128'd0);
        check("t1_post_we",    {127'd0, mem_we}, 128'd0);
        check("t1_mem104",     {120'd0, mem[16'h0104]}, 128'h54);
        check("t1_mem105",     {120'd0, mem[16'h0105]}, 128'h00);
        check("t1_wr_count",   128'(wr_log.size()), 128'd5);

        // 2: scalar store then load
        wr_log.delete();
        do_scalar(1'b1, 16'h0010, 8'hA5, 8'h00);
        check("t2_st_wr_count", 128'(wr_log.size()), 128'd1);
        if (wr_log.size() > 0) begin
            check("t2_st_addr", {112'd0, wr_log[0].addr}, 128'h0010);
            check("t2_st_data", {120'd0, wr_log[0].data}, 128'hA5);
        end
        wr_log.delete();
        do_scalar(1'b0, 16'h0010, 8'h00, 8'hA5);
        check("t2_ld_stall", {125'd0, stall_tr[1], stall_tr[2], stall_tr[3]}, 128'b110);
        check("t2_ld_no_wr", 128'(wr_log.size()), 128'd0);

        // 3: vector store/load round trip
        wr_log.delete();
        do_vector(1'b1, 16'h0200, PAT_RAMP, 128'd0, 17);
        check("t3_wr_count", 128'(wr_log.size()), 128'd16);
        ok = (wr_log.size() == 16);
        for (int k = 0; k < 16 && ok; k++) begin
            if (wr_log[k].addr != 16'h0200 + 16'(k) || wr_log[k].data != 8'(k) ||
                wr_log[k].cy != wr_log[0].cy + k) ok = 0;
        end
        check("t3_wr_sequence", {127'd0, ok}, 128'd1);
        do_vector(1'b0, 16'h0200, 128'd0, PAT_RAMP, 18);

        // 4: address wrap on a vector load
        wr_log.delete();
        do_vector(1'b0, 16'hFFF8, 128'd0, PAT_WRAP, 18);
        check("t4_no_wr", 128'(wr_log.size()), 128'd0);

        // 5: simultaneous requests, scalar wins
        @(posedge clk);
        #1;
        scalar_we   = 1'b0;
        scalar_addr = 16'h0010;
        vector_we   = 1'b0;
        vector_addr = 16'h0200;
        scalar_req  = 1'b1;
        vector_req  = 1'b1;
        push_exp(1'b0, 1'b1, 128'hA5, 3);
        push_exp(1'b1, 1'b1, PAT_RAMP, 22);
        wait_done(1'b0, 20);
        check("t5_done_stall", {127'd0, stall}, 128'd1);
        scalar_req = 1'b0;
        wait_done(1'b1, 40);
        vector_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single byte-wide data-memory port between scalar (8-bit) and vector (128-bit, 16 lanes) accesses issued from the memory stage.
- Serializes each vector load/store into 16 byte accesses.
- Returns read data, pulses a per-requester done, and drives the pipeline stall so the EX/MEM stage holds until the access completes.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, memory data width (one lane)
LANES, 16, bytes per vector access (vector width = LANES*DATA_W = 128)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
scalar_req  in  1  scalar access request; held stable until scalar_done
scalar_we  in  1  1 = store, 0 = load
scalar_addr  in  ADDR_W  byte address
scalar_wdata  in  DATA_W  store data
scalar_rdata  out  DATA_W  load data, valid while scalar_done=1
scalar_done  out  1  one-cycle completion pulse
vector_req  in  1  vector access request; held stable until vector_done
vector_we  in  1  1 = store, 0 = load
vector_addr  in  ADDR_W  base byte address, lane 0
vector_wdata  in  128  store data, lane k = bits [8k+7:8k]
vector_rdata  out  128  load data, valid while vector_done=1
vector_done  out  1  one-cycle completion pulse
stall  out  1  freeze pipeline registers upstream of memory stage
mem_addr  out  ADDR_W  memory address (registered)
mem_we  out  1  memory write enable (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address presented

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset=0, all registered outputs and state clear immediately:
  - outputs: mem_addr=0, mem_we=0, mem_wdata=0, scalar_rdata=0, vector_rdata=0, scalar_done=0, vector_done=0
  - state: state=IDLE, lane counter=0
  - stall follows its IDLE equation.
- Reset mid-transaction abandons the access. mem_we drops the same instant. No done pulse is issued.
- FSM states: IDLE, S_ACC, S_RESP, V_ACC, V_DRAIN, DONE.
- IDLE:
  - At a clock edge, if scalar_req=1, latch scalar we/addr/wdata and go to S_ACC.
  - Otherwise, if vector_req=1, latch vector we/addr/wdata, clear lane counter, and go to V_ACC.
  - Scalar has fixed priority when both are asserted.
  - mem_we=0 in IDLE.
- S_ACC (1 cycle): mem_addr=addr, mem_we=we, mem_wdata=wdata. Next state S_RESP.
- S_RESP (1 cycle): mem_we=0. At the edge, capture mem_rdata into scalar_rdata (loads only; stores leave scalar_rdata unchanged). Next state DONE.
- V_ACC (16 cycles, lane k=0..15):
  - Address and write: mem_addr=(base+k) mod 2^ADDR_W, so address wraps 0xFFFF->0x0000. mem_we=we. mem_wdata=lane k of wdata.
  - Load capture: for loads, mem_rdata arriving in the cycle after lane k is written into vector_rdata lane k.
  - Exit at k=15: stores go to DONE; loads go to V_DRAIN.
- V_DRAIN (loads only, 1 cycle): mem_we=0. Capture lane 15. Next state DONE.
- DONE (1 cycle):
  - Pulse scalar_done or vector_done, whichever was served. mem_we=0.
  - Next state IDLE. A request still asserted is re-arbitrated in IDLE, so back-to-back accesses cost one IDLE cycle.
- Latency, measured from the accepting edge to the done pulse:
  - scalar load or store: done in 3rd cycle
  - vector store: done in 17th cycle
  - vector load: done in 18th cycle
- stall equations:
  - IDLE: stall = scalar_req | vector_req (combinational)
  - S_ACC, S_RESP, V_ACC, V_DRAIN: stall = 1
  - DONE: stall = 1 only if the non-served request is asserted; otherwise 0, letting the pipeline advance in the done cycle.
- Requests deasserted mid-transaction are ignored; the latched copy completes.
- vector_rdata and scalar_rdata hold their last value until overwritten.

Test Plan:
1. Reset mid-vector-store: assert vector_req, we=1, addr=0x0100. Drop reset to 0 at lane 5 → mem_we=0 immediately; no vector_done; after reset release, state IDLE and stall=0 with no requests; memory holds 0x0100–0x0104 only.
2. Scalar store then load: store addr=0x0010, wdata=0xA5 → mem_we=1 with mem_addr=0x0010 for exactly 1 cycle, scalar_done in 3rd cycle. Then load addr=0x0010 → scalar_rdata=0xA5 with scalar_done; stall high through S_RESP, low in DONE.
3. Vector store/load round trip: store base=0x0200, wdata=0x0F0E…0100 (lane k = k) → 16 consecutive mem_we cycles, addresses 0x0200–0x020F, vector_done in cycle 17. Then load → vector_rdata equals written pattern, vector_done in cycle 18.
4. Address wrap: vector load base=0xFFF8 → mem_addr sequence 0xFFF8…0xFFFF, 0x0000…0x0007; lanes 0–7 from top of memory, lanes 8–15 from bottom.
5. Simultaneous requests: scalar_req and vector_req both rise in the same cycle → scalar served first (scalar_done at cycle 3); stall stays 1 in DONE; vector starts after one IDLE cycle and completes normally.
